cache_op_ctrl: RTL and testbench

//  Sequences MIPS CACHE instructions committed in WB. Consumes cache_op/index/tag/valid/dirty driven by the CP0

---
 rtl/cache_op_ctrl_pkg.sv | 49 ++++
 rtl/cache_op_ctrl_if.sv | 61 ++++++
 rtl/cache_op_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_op_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_op_ctrl_pkg.sv
// Shared types for the CACHE-instruction sequencer.
//   CacheCodeType : MIPS CACHE op field {op[4:2], cache[1:0]} as delivered by CP0
//   ic_code_t     : I-cache maintenance command codes
//   dc_code_t     : D-cache maintenance command codes
//   cop_state_t   : sequencer FSM states
package cache_op_ctrl_pkg;

  localparam int unsigned IndexW = 8;
  localparam int unsigned TagW   = 20;
  localparam int unsigned WayW   = 2;

  typedef enum logic [4:0] {
    I_Index_Invalid           = 5'b000_00,
    D_Index_Writeback_Invalid = 5'b000_01,
    I_Index_Load_Tag          = 5'b001_00,
    D_Index_Load_Tag          = 5'b001_01,
    I_Index_Store_Tag         = 5'b010_00,
    D_Index_Store_Tag         = 5'b010_01,
    I_Hit_Invalid             = 5'b100_00,
    D_Hit_Invalid             = 5'b100_01,
    I_Fill                    = 5'b101_00,
    D_Hit_Writeback_Invalid   = 5'b101_01,
    D_Hit_Writeback           = 5'b110_01
  } CacheCodeType;

  typedef enum logic [1:0] {
    IcIdxInv  = 2'd0,
    IcIdxStag = 2'd1,
    IcHitInv  = 2'd2
  } ic_code_t;

  typedef enum logic [2:0] {
    DcLookupIdx = 3'd0,
    DcLookupHit = 3'd1,
    DcStag      = 3'd2,
    DcInv       = 3'd3,
    DcWb        = 3'd4
  } dc_code_t;

  typedef enum logic [2:0] {
    StIdle, StICmd, StDCmd, StDLook, StDWb, StDInv, StDone
  } cop_state_t;

  // Ops whose dirty lines must be written back before invalidation.
  function automatic logic is_wb_op(CacheCodeType op);
    return (op == D_Index_Writeback_Invalid) || (op == D_Hit_Writeback_Invalid);
  endfunction

endpackage

// File: rtl/cache_op_ctrl_if.sv
// Bundle of the WB request, I-cache command and D-cache command channels.
//   master : the sequencer (consumes req_*, drives c0_stall and cache commands)
//   slave  : the pipeline/cache side
interface cache_op_ctrl_if
  import cache_op_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_W = IndexW,
  parameter int unsigned TAG_W   = TagW,
  parameter int unsigned WAY_W   = WayW
) ();

  logic               req_valid;
  CacheCodeType       req_op;
  logic [INDEX_W-1:0] req_index;
  logic [WAY_W-1:0]   req_way;
  logic [TAG_W-1:0]   req_tag;
  logic               req_tag_v;
  logic               req_tag_d;
  logic               c0_stall;

  logic               ic_valid;
  logic               ic_ready;
  ic_code_t           ic_code;
  logic [INDEX_W-1:0] ic_index;
  logic [WAY_W-1:0]   ic_way;
  logic [TAG_W-1:0]   ic_tag;
  logic               ic_tag_v;
  logic               ic_done;

  logic               dc_valid;
  logic               dc_ready;
  dc_code_t           dc_code;
  logic [INDEX_W-1:0] dc_index;
  logic [WAY_W-1:0]   dc_way;
  logic [TAG_W-1:0]   dc_tag;
  logic               dc_tag_v;
  logic               dc_tag_d;
  logic               dc_rsp_valid;
  logic               dc_rsp_hit;
  logic [WAY_W-1:0]   dc_rsp_way;
  logic               dc_rsp_dirty;

  modport master (
    input  req_valid, req_op, req_index, req_way, req_tag, req_tag_v, req_tag_d,
    output c0_stall,
    output ic_valid, ic_code, ic_index, ic_way, ic_tag, ic_tag_v,
    input  ic_ready, ic_done,
    output dc_valid, dc_code, dc_index, dc_way, dc_tag, dc_tag_v, dc_tag_d,
    input  dc_ready, dc_rsp_valid, dc_rsp_hit, dc_rsp_way, dc_rsp_dirty
  );

  modport slave (
    output req_valid, req_op, req_index, req_way, req_tag, req_tag_v, req_tag_d,
    input  c0_stall,
    input  ic_valid, ic_code, ic_index, ic_way, ic_tag, ic_tag_v,
    output ic_ready, ic_done,
    input  dc_valid, dc_code, dc_index, dc_way, dc_tag, dc_tag_v, dc_tag_d,
    output dc_ready, dc_rsp_valid, dc_rsp_hit, dc_rsp_way, dc_rsp_dirty
  );

endinterface

// File: rtl/cache_op_ctrl.sv
// Sequences a MIPS CACHE instruction held in WB onto the I-/D-cache maintenance ports.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : request/stall and I/D cache command channels (master side)
//   wdog_err    : sticky, a cache port failed to respond within WDOG_CYC cycles
//   ops_done    : wrapping count of completed CACHE ops
module cache_op_ctrl
  import cache_op_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_W  = IndexW,
  parameter int unsigned TAG_W    = TagW,
  parameter int unsigned WAY_W    = WayW,
  parameter int unsigned WDOG_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  cache_op_ctrl_if.master       bus,
  output logic                  wdog_err,
  output logic [31:0]           ops_done
);

  localparam int unsigned WdogW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_CYC - 1);

  cop_state_t         state_q, state_d;
  CacheCodeType       op_q, op_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               tag_v_q, tag_v_d;
  logic               tag_dirty_q, tag_dirty_d;
  logic               issued_q, issued_d;  // command accepted, now waiting for completion
  logic [WdogW-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic               wdog_err_q, wdog_err_d;
  logic [31:0]        ops_done_q, ops_done_d;

  logic wait_st, cmd_valid, cmd_ready, rsp_in, rsp_ok;

  always_comb begin
    wait_st   = (state_q != StIdle) && (state_q != StDone);
    cmd_valid = wait_st && !issued_q;
    cmd_ready = (state_q == StICmd) ? bus.ic_ready : bus.dc_ready;
    rsp_in    = (state_q == StICmd) ? bus.ic_done : bus.dc_rsp_valid;
    // A response in the same cycle as the ready handshake is accepted.
    rsp_ok    = wait_st && rsp_in && (issued_q || (cmd_valid && cmd_ready));
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    way_d       = way_q;
    tag_d       = tag_q;
    tag_v_d     = tag_v_q;
    tag_dirty_d = tag_dirty_q;
    ops_done_d  = ops_done_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d        = bus.req_op;
          index_d     = bus.req_index;
          way_d       = bus.req_way;
          tag_d       = bus.req_tag;
          tag_v_d     = bus.req_tag_v;
          tag_dirty_d = bus.req_tag_d;
          case (bus.req_op)
            I_Index_Invalid, I_Index_Store_Tag, I_Hit_Invalid: state_d = StICmd;
            D_Index_Store_Tag:                                 state_d = StDCmd;
            D_Index_Writeback_Invalid, D_Hit_Invalid,
            D_Hit_Writeback_Invalid:                           state_d = StDLook;
            default:                                           state_d = StDone;
          endcase
        end
      end
      StICmd, StDCmd, StDInv: if (rsp_ok) state_d = StDone;
      StDLook: begin
        if (rsp_ok) begin
          if (!bus.dc_rsp_hit) begin
            state_d = StDone;
          end else begin
            way_d   = bus.dc_rsp_way;
            state_d = (bus.dc_rsp_dirty && is_wb_op(op_q)) ? StDWb : StDInv;
          end
        end
      end
      StDWb: if (rsp_ok) state_d = StDInv;
      StDone: begin
        ops_done_d = ops_done_q + 32'd1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    issued_d = (state_d != state_q) ? 1'b0 : (issued_q || (cmd_valid && cmd_ready));

    // Counts wait-state cycles; saturates so the sticky flag cannot be missed.
    wdog_err_d = wdog_err_q;
    if (state_d != state_q || !wait_st) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q == WdogMax) begin
      wdog_cnt_d = wdog_cnt_q;
      wdog_err_d = 1'b1;
    end else begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_q        <= I_Index_Invalid;
      index_q     <= '0;
      way_q       <= '0;
      tag_q       <= '0;
      tag_v_q     <= 1'b0;
      tag_dirty_q <= 1'b0;
      issued_q    <= 1'b0;
      wdog_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      index_q     <= index_d;
      way_q       <= way_d;
      tag_q       <= tag_d;
      tag_v_q     <= tag_v_d;
      tag_dirty_q <= tag_dirty_d;
      issued_q    <= issued_d;
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_err_q  <= wdog_err_d;
      ops_done_q  <= ops_done_d;
    end
  end

  always_comb begin
    bus.c0_stall = bus.req_valid && (state_q != StDone);

    bus.ic_valid = cmd_valid && (state_q == StICmd);
    case (op_q)
      I_Index_Store_Tag: bus.ic_code = IcIdxStag;
      I_Hit_Invalid:     bus.ic_code = IcHitInv;
      default:           bus.ic_code = IcIdxInv;
    endcase
    bus.ic_index = index_q;
    bus.ic_way   = way_q;
    bus.ic_tag   = tag_q;
    bus.ic_tag_v = tag_v_q;

    bus.dc_valid = cmd_valid && (state_q != StICmd);
    case (state_q)
      StDLook: bus.dc_code = (op_q == D_Index_Writeback_Invalid) ? DcLookupIdx : DcLookupHit;
      StDWb:   bus.dc_code = DcWb;
      StDInv:  bus.dc_code = DcInv;
      default: bus.dc_code = DcStag;
    endcase
    bus.dc_index = index_q;
    bus.dc_way   = way_q;
    bus.dc_tag   = tag_q;
    bus.dc_tag_v = tag_v_q;
    bus.dc_tag_d = tag_dirty_q;
  end

  assign wdog_err = wdog_err_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_cache_op_ctrl.sv
// Directed bench for cache_op_ctrl: expected cache commands go into a scoreboard queue when a
// request is issued and are popped and compared as the DUT presents them.
module tb_cache_op_ctrl;
  import cache_op_ctrl_pkg::*;

  typedef struct packed {
    logic        is_dc;
    logic [2:0]  code;
    logic [7:0]  index;
    logic [1:0]  way;
    logic [19:0] tag;
    logic        v;
    logic        d;
  } cmd_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wdog_err;
  logic [31:0] ops_done;

  int   n_chk = 0;
  int   n_err = 0;
  int   stall_cnt = 0;
  cmd_t sb[$];
  cmd_t cur;

  cache_op_ctrl_if bus ();

  cache_op_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .wdog_err (wdog_err),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.c0_stall) stall_cnt++;
  endtask

  function automatic cmd_t obs_cmd(input logic is_dc);
    cmd_t c;
    if (is_dc) begin
      c.is_dc = 1'b1;
      c.code  = 3'(bus.dc_code);
      c.index = bus.dc_index;
      c.way   = bus.dc_way;
      c.tag   = bus.dc_tag;
      c.v     = bus.dc_tag_v;
      c.d     = bus.dc_tag_d;
    end else begin
      c.is_dc = 1'b0;
      c.code  = {1'b0, 2'(bus.ic_code)};
      c.index = bus.ic_index;
      c.way   = bus.ic_way;
      c.tag   = bus.ic_tag;
      c.v     = bus.ic_tag_v;
      c.d     = 1'b0;
    end
    return c;
  endfunction

  task automatic issue(input CacheCodeType op, input logic [7:0] idx, input logic [1:0] way,
                       input logic [19:0] tag, input logic v, input logic d);
    bus.req_op    = op;
    bus.req_index = idx;
    bus.req_way   = way;
    bus.req_tag   = tag;
    bus.req_tag_v = v;
    bus.req_tag_d = d;
    bus.req_valid = 1'b1;
    stall_cnt     = 0;
  endtask

  task automatic push(input logic is_dc, input logic [2:0] code, input logic [7:0] idx,
                      input logic [1:0] way, input logic [19:0] tag, input logic v,
                      input logic d);
    sb.push_back('{is_dc, code, idx, way, tag, v, d});
  endtask

  // Pop the next expected command and wait (bounded) for the DUT to present it.
  task automatic expect_cmd();
    logic seen;
    seen = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 64'd0, 64'd1);
      return;
    end
    cur = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      if (cur.is_dc ? bus.dc_valid : bus.ic_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("cmd_valid", 64'(seen), 64'd1);
    chk("cmd_fields", 64'(obs_cmd(cur.is_dc)), 64'(cur));
    chk("other_port_idle", 64'(cur.is_dc ? bus.ic_valid : bus.dc_valid), 64'd0);
  endtask

  // rsp_delay: 0 = response with ready, n = n cycles after ready, -1 = no response.
  task automatic handshake(input int rdy_wait, input int rsp_delay, input logic hit,
                           input logic [1:0] rway, input logic dirty);
    for (int i = 0; i < rdy_wait; i++) begin
      step();
      chk("valid_held", 64'(cur.is_dc ? bus.dc_valid : bus.ic_valid), 64'd1);
      chk("fields_stable", 64'(obs_cmd(cur.is_dc)), 64'(cur));
    end
    if (cur.is_dc) bus.dc_ready = 1'b1;
    else           bus.ic_ready = 1'b1;
    bus.dc_rsp_hit   = hit;
    bus.dc_rsp_way   = rway;
    bus.dc_rsp_dirty = dirty;
    if (rsp_delay == 0) begin
      if (cur.is_dc) bus.dc_rsp_valid = 1'b1;
      else           bus.ic_done = 1'b1;
    end
    step();
    bus.ic_ready     = 1'b0;
    bus.dc_ready     = 1'b0;
    bus.ic_done      = 1'b0;
    bus.dc_rsp_valid = 1'b0;
    if (rsp_delay > 0) begin
      chk("valid_dropped", 64'(cur.is_dc ? bus.dc_valid : bus.ic_valid), 64'd0);
      for (int i = 1; i < rsp_delay; i++) step();
      if (cur.is_dc) bus.dc_rsp_valid = 1'b1;
      else           bus.ic_done = 1'b1;
      step();
      bus.ic_done      = 1'b0;
      bus.dc_rsp_valid = 1'b0;
    end
  endtask

  task automatic finish_op(input int exp_ops);
    chk("stall_released", 64'(bus.c0_stall), 64'd0);
    bus.req_valid = 1'b0;
    step();
    chk("ops_done", 64'(ops_done), 64'(exp_ops));
    chk("idle_no_stall", 64'(bus.c0_stall), 64'd0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_op       = I_Index_Invalid;
    bus.req_index    = '0;
    bus.req_way      = '0;
    bus.req_tag      = '0;
    bus.req_tag_v    = 1'b0;
    bus.req_tag_d    = 1'b0;
    bus.ic_ready     = 1'b0;
    bus.ic_done      = 1'b0;
    bus.dc_ready     = 1'b0;
    bus.dc_rsp_valid = 1'b0;
    bus.dc_rsp_hit   = 1'b0;
    bus.dc_rsp_way   = '0;
    bus.dc_rsp_dirty = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_ic_valid", 64'(bus.ic_valid), 64'd0);
    chk("rst_dc_valid", 64'(bus.dc_valid), 64'd0);
    chk("rst_wdog", 64'(wdog_err), 64'd0);
    chk("rst_stall", 64'(bus.c0_stall), 64'd0);
    resetn = 1'b1;
    step();

    // 1: I_Index_Invalid, ready at issue, done one cycle later
    issue(I_Index_Invalid, 8'h3A, 2'd2, 20'h12345, 1'b0, 1'b0);
    push(1'b0, 3'd0, 8'h3A, 2'd2, 20'h12345, 1'b0, 1'b0);
    expect_cmd();
    handshake(0, 1, 1'b0, 2'd0, 1'b0);
    chk("t1_stall_cycles", 64'(stall_cnt), 64'd2);
    finish_op(1);

    // 2: D_Index_Writeback_Invalid, dirty hit in way 3 -> lookup, WB, INV
    issue(D_Index_Writeback_Invalid, 8'h10, 2'd1, 20'h00055, 1'b1, 1'b1);
    push(1'b1, 3'd0, 8'h10, 2'd1, 20'h00055, 1'b1, 1'b1);
    push(1'b1, 3'd4, 8'h10, 2'd3, 20'h00055, 1'b1, 1'b1);
    push(1'b1, 3'd3, 8'h10, 2'd3, 20'h00055, 1'b1, 1'b1);
    expect_cmd();
    handshake(0, 0, 1'b1, 2'd3, 1'b1);
    expect_cmd();
    handshake(1, 2, 1'b0, 2'd0, 1'b0);
    expect_cmd();
    handshake(0, 1, 1'b0, 2'd0, 1'b0);
    finish_op(2);

    // 3a: D_Hit_Invalid never writes back a dirty hit
    issue(D_Hit_Invalid, 8'h20, 2'd0, 20'h00777, 1'b1, 1'b0);
    push(1'b1, 3'd1, 8'h20, 2'd0, 20'h00777, 1'b1, 1'b0);
    push(1'b1, 3'd3, 8'h20, 2'd2, 20'h00777, 1'b1, 1'b0);
    expect_cmd();
    handshake(0, 1, 1'b1, 2'd2, 1'b1);
    expect_cmd();
    handshake(0, 0, 1'b0, 2'd0, 1'b0);
    finish_op(3);

    // 3b: D_Hit_Writeback_Invalid miss finishes after the lookup
    issue(D_Hit_Writeback_Invalid, 8'h21, 2'd0, 20'h00888, 1'b0, 1'b0);
    push(1'b1, 3'd1, 8'h21, 2'd0, 20'h00888, 1'b0, 1'b0);
    expect_cmd();
    handshake(0, 1, 1'b0, 2'd1, 1'b1);
    finish_op(4);

    // 4: D_Index_Store_Tag with ready withheld 5 cycles; request changes are ignored
    issue(D_Index_Store_Tag, 8'h44, 2'd1, 20'hABCDE, 1'b1, 1'b0);
    push(1'b1, 3'd2, 8'h44, 2'd1, 20'hABCDE, 1'b1, 1'b0);
    expect_cmd();
    bus.req_index = 8'hFF;
    bus.req_tag   = 20'h11111;
    handshake(5, 1, 1'b0, 2'd0, 1'b0);
    finish_op(5);

    // Unsupported code: no cache command, single stall cycle
    issue(I_Index_Load_Tag, 8'h01, 2'd0, 20'h0, 1'b0, 1'b0);
    step();
    chk("noop_ic_valid", 64'(bus.ic_valid), 64'd0);
    chk("noop_dc_valid", 64'(bus.dc_valid), 64'd0);
    finish_op(6);

    // 5: I_Hit_Invalid accepted but never completed -> watchdog, then late completion
    chk("t5_wdog_before", 64'(wdog_err), 64'd0);
    issue(I_Hit_Invalid, 8'h05, 2'd0, 20'h09ABC, 1'b0, 1'b0);
    push(1'b0, 3'd2, 8'h05, 2'd0, 20'h09ABC, 1'b0, 1'b0);
    expect_cmd();
    handshake(0, -1, 1'b0, 2'd0, 1'b0);
    repeat (1000) step();
    chk("t5_wdog_early", 64'(wdog_err), 64'd0);
    repeat (100) step();
    chk("t5_wdog_set", 64'(wdog_err), 64'd1);
    chk("t5_still_stalled", 64'(bus.c0_stall), 64'd1);
    bus.ic_done = 1'b1;
    step();
    bus.ic_done = 1'b0;
    finish_op(7);
    chk("t5_wdog_sticky", 64'(wdog_err), 64'd1);

    // 6: asynchronous reset while the writeback command is pending
    issue(D_Hit_Writeback_Invalid, 8'h7F, 2'd0, 20'h00001, 1'b1, 1'b1);
    push(1'b1, 3'd1, 8'h7F, 2'd0, 20'h00001, 1'b1, 1'b1);
    push(1'b1, 3'd4, 8'h7F, 2'd1, 20'h00001, 1'b1, 1'b1);
    expect_cmd();
    handshake(0, 0, 1'b1, 2'd1, 1'b1);
    expect_cmd();
    bus.req_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("t6_dc_valid", 64'(bus.dc_valid), 64'd0);
    chk("t6_ic_valid", 64'(bus.ic_valid), 64'd0);
    chk("t6_ops_done", 64'(ops_done), 64'd0);
    chk("t6_wdog", 64'(wdog_err), 64'd0);
    chk("t6_stall", 64'(bus.c0_stall), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // Recovery after reset
    issue(I_Index_Store_Tag, 8'h99, 2'd3, 20'h0BEEF, 1'b1, 1'b0);
    push(1'b0, 3'd1, 8'h99, 2'd3, 20'h0BEEF, 1'b1, 1'b0);
    expect_cmd();
    handshake(0, 0, 1'b0, 2'd0, 1'b0);
    finish_op(1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
